bsort_main: RTL and testbench
=============================

# bsort_main

Hardware bubble-sort accelerator: on a start pulse it fills an internal 100-entry array of signed 32-bit integers with a fixed pattern, sorts it ascending in place, and pulses done. It is the top-level kernel of the bsort100 benchmark and sits behind the standard two-channel slave memory port. A host or bench can read or write the array through that port while the kernel is idle.

## Interface
- MEM_var_26078_26084, default 256: byte base address of the array in the slave address map. The array occupies 400 bytes starting here.
- clock  in  1: single clock, all logic on rising edge.
- reset  in  1: asynchronous, active-low reset.
- start_port  in  1: one-cycle start pulse.
- S_oe_ram  in  2: per-channel read enable (channel c = bit c).
- S_we_ram  in  2: per-channel write enable.
- S_addr_ram  in  20: per-channel byte address, 10 bits each; channel c = bits [10c+9:10c].
- S_Wdata_ram  in  128: per-channel write data, 64 bits each.
- S_data_ram_size  in  14: per-channel access size in bits, 7 bits each. Only 32 is legal.
- done_port  out  1: one-cycle completion pulse.
- Sout_Rdata_ram  out  128: per-channel read data, 64 bits each. The word is in the low 32 bits, and the upper bits are 0.
- Sout_DataRdy  out  2: per-channel access acknowledge.

## Operation
- FSM states:
  - IDLE: waits for start_port.
  - INIT: writes A[i] = -i for i = 0..99, one word per cycle.
  - OUTER: starts a pass, clears the swapped flag, sets j = 0.
  - READ: fetches A[j] and A[j+1], one word per port of the dual-port RAM.
  - CMP: compares the two words, signed.
  - SWAP: writes the swapped pair back and sets the swapped flag.
  - NEXT: advances j, or ends the pass.
  - DONE: pulses done_port and returns to IDLE.
- Pass p (p = 0..98) compares j = 0..98-p.
- A swap happens when A[j] > A[j+1] as signed values. Equal values are never swapped.
- Sorting ends after 99 passes, or earlier as described in Configuration.
- start_port is ignored unless the FSM is in IDLE.
- Slave port, per channel c, accepted only in IDLE:
  - Address decode is word = (addr - base) >> 2, valid while addr - base < 400.
  - Write: stores Wdata[31:0] to the decoded word.
  - Read: returns the decoded word.
  - Out-of-range or busy-time accesses return Rdata 0 with no acknowledge and no write.
- If both channels write the same word in the same cycle, channel 1 wins.

## Timing
- Reset values: done_port 0, Sout_DataRdy 0, Sout_Rdata_ram 0, FSM in IDLE. Array contents are undefined.
- Reset asserted mid-sort aborts immediately to IDLE. No done pulse is produced.
- The first INIT write happens in the cycle after start_port is sampled high.
- Internal RAM read latency is 1 cycle, giving 3 cycles per compare without swap and 4 with swap.
- done_port is high for exactly one cycle, the cycle after the last compare or write.
- If start_port is high in that same cycle, it is ignored.
- Slave read: Sout_DataRdy[c] and Rdata are valid exactly 2 cycles after oe is sampled.
- Slave write: Sout_DataRdy[c] is high 1 cycle after we is sampled.
- Back-to-back slave accesses are allowed every cycle.

## Configuration
- BSORT_EARLY_EXIT_EN defined: a pass with no swap ends sorting immediately and goes to DONE.
- BSORT_EARLY_EXIT_EN not defined: all 99 passes always run.
- The final array contents are identical in both cases.

## Structure
- Package bsort_pkg holds:
  - N = 100 and word width 32.
  - Index width 7.
  - Slave channel count 2, address width 10, data width 64, size width 7.
  - The FSM state enum.
- One sub-module, bsort_ram: 100x32 true dual-port synchronous RAM with 1-cycle read latency.
  - Port A is shared between the FSM and slave channel 0.
  - Port B is shared between the FSM and slave channel 1.
  - The FSM owns both ports whenever it is not in IDLE.

## Test plan
- Reset low for 2 cycles, then start pulse -> done_port pulses once. A[0..99] reads back -99..0 ascending: word 0 = 0xFFFFFF9D, word 99 = 0.
- Without a start pulse: slave write 0x5 to addr 256 and 0x3 to addr 260 -> DataRdy after 1 cycle. Reads at addr 256 and 260 return 5 and 3 after 2 cycles.
- Slave read at addr 656 (out of range) -> DataRdy stays 0, Rdata 0.
- Assert reset mid-sort, release, start again -> a single done pulse and a correctly sorted array.
- With BSORT_EARLY_EXIT_EN, start on an already-sorted array by preloading via slave then starting with INIT bypassed in the test variant -> done within about 350 cycles. Without it, done takes about 15000 cycles.
- Both channels write the same word in the same cycle with values 1 and 2 -> a subsequent read returns 2.

Source files
------------

// File: rtl/bsort_pkg.sv
// rtl/bsort_pkg.sv - shared sizes, slave-port geometry and FSM states for the bsort100 kernel
package bsort_pkg;
    localparam int N      = 100;
    localparam int W      = 32;
    localparam int IDX_W  = 7;
    localparam int NCH    = 2;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int SIZE_W = 7;

    localparam int ARRAY_BYTES = N * 4;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]  LAST_PASS  = IDX_W'(N - 2);
    localparam logic [SIZE_W-1:0] SIZE_LEGAL = SIZE_W'(W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_OUTER,
        S_READ,
        S_CMP,
        S_SWAP,
        S_NEXT,
        S_DONE
    } state_t;
endpackage

// File: rtl/bsort_ram.sv
// rtl/bsort_ram.sv - 100x32 true dual-port RAM, 1-cycle registered read, port B wins write collisions
module bsort_ram
    import bsort_pkg::*;
(
    input  logic             clk,
    input  logic             i_a_we,
    input  logic [IDX_W-1:0] i_a_addr,
    input  logic [W-1:0]     i_a_wdata,
    output logic [W-1:0]     o_a_rdata,
    input  logic             i_b_we,
    input  logic [IDX_W-1:0] i_b_addr,
    input  logic [W-1:0]     i_b_wdata,
    output logic [W-1:0]     o_b_rdata
);
    logic [W-1:0] r_mem [0:N-1];
    logic [W-1:0] r_a_rdata;
    logic [W-1:0] r_b_rdata;

    // Port B is written last so it takes precedence on a same-address collision.
    always_ff @(posedge clk) begin
        if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
        if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
        r_a_rdata <= r_mem[i_a_addr];
        r_b_rdata <= r_mem[i_b_addr];
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;
endmodule

// File: rtl/bsort_main.sv
// rtl/bsort_main.sv - bubble-sort kernel with two-channel slave memory port; BSORT_EARLY_EXIT_EN stops after a swap-free pass
module bsort_main
    import bsort_pkg::*;
#(
    parameter int MEM_var_26078_26084 = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_port,
    input  logic [NCH-1:0]          S_oe_ram,
    input  logic [NCH-1:0]          S_we_ram,
    input  logic [NCH*ADDR_W-1:0]   S_addr_ram,
    input  logic [NCH*DATA_W-1:0]   S_Wdata_ram,
    input  logic [NCH*SIZE_W-1:0]   S_data_ram_size,
    output logic                    done_port,
    output logic [NCH*DATA_W-1:0]   Sout_Rdata_ram,
    output logic [NCH-1:0]          Sout_DataRdy
);
    localparam logic [ADDR_W:0] BASE = (ADDR_W + 1)'(MEM_var_26078_26084);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(ARRAY_BYTES);
`ifdef BSORT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] r_pass;
    logic [IDX_W-1:0] w_last_j;
    logic             r_swapped;
    logic             w_idle;

    logic [NCH-1:0]                  w_hit;
    logic [NCH-1:0]                  w_rd;
    logic [NCH-1:0]                  w_wr;
    logic [NCH-1:0]                  r_rd_pend;
    logic [NCH-1:0][IDX_W-1:0]       w_word;
    logic [NCH-1:0][W-1:0]           w_wdata;
    logic [NCH-1:0][DATA_W-W-1:0]    w_wdata_hi;
    logic [NCH-1:0][W-1:0]           w_ram_rdata;
    logic [NCH-1:0][W-1:0]           r_rdata;
    logic                            w_unused_wdata;

    logic             w_fsm_a_we;
    logic             w_fsm_b_we;
    logic [IDX_W-1:0] w_fsm_a_addr;
    logic [IDX_W-1:0] w_fsm_b_addr;
    logic [W-1:0]     w_fsm_a_wdata;
    logic [W-1:0]     w_fsm_b_wdata;

    logic             w_a_we;
    logic             w_b_we;
    logic [IDX_W-1:0] w_a_addr;
    logic [IDX_W-1:0] w_b_addr;
    logic [W-1:0]     w_a_wdata;
    logic [W-1:0]     w_b_wdata;
    logic [W-1:0]     w_a_rdata;
    logic [W-1:0]     w_b_rdata;

    assign w_idle   = (r_state == S_IDLE);
    assign w_last_j = LAST_PASS - r_pass;

    // Slave decode: addresses below the base wrap in the subtraction and are rejected by the compare.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [ADDR_W:0] w_addr;
        logic [ADDR_W:0] w_off;
        assign w_addr        = {1'b0, S_addr_ram[c*ADDR_W +: ADDR_W]};
        assign w_off         = w_addr - BASE;
        assign w_hit[c]      = (w_addr >= BASE) && (w_off < SPAN)
                               && (S_data_ram_size[c*SIZE_W +: SIZE_W] == SIZE_LEGAL);
        assign w_word[c]     = w_off[IDX_W+1:2];
        assign w_rd[c]       = w_idle && S_oe_ram[c] && w_hit[c];
        assign w_wr[c]       = w_idle && S_we_ram[c] && w_hit[c];
        assign w_wdata[c]    = S_Wdata_ram[c*DATA_W +: W];
        assign w_wdata_hi[c] = S_Wdata_ram[c*DATA_W+W +: DATA_W-W];
        assign Sout_Rdata_ram[c*DATA_W +: DATA_W] = {{(DATA_W-W){1'b0}}, r_rdata[c]};
    end

    assign w_unused_wdata = ^w_wdata_hi;
    assign w_ram_rdata[0] = w_a_rdata;
    assign w_ram_rdata[1] = w_b_rdata;

    assign w_a_we    = w_idle ? w_wr[0]    : w_fsm_a_we;
    assign w_a_addr  = w_idle ? w_word[0]  : w_fsm_a_addr;
    assign w_a_wdata = w_idle ? w_wdata[0] : w_fsm_a_wdata;
    assign w_b_we    = w_idle ? w_wr[1]    : w_fsm_b_we;
    assign w_b_addr  = w_idle ? w_word[1]  : w_fsm_b_addr;
    assign w_b_wdata = w_idle ? w_wdata[1] : w_fsm_b_wdata;

    bsort_ram u_ram (
        .clk       (clock),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (w_a_wdata),
        .o_a_rdata (w_a_rdata),
        .i_b_we    (w_b_we),
        .i_b_addr  (w_b_addr),
        .i_b_wdata (w_b_wdata),
        .o_b_rdata (w_b_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Addresses stay on j/j+1 through CMP, so the RAM outputs still hold the pair during SWAP.
    always_comb begin
        w_next        = r_state;
        done_port     = 1'b0;
        w_fsm_a_we    = 1'b0;
        w_fsm_b_we    = 1'b0;
        w_fsm_a_addr  = r_j;
        w_fsm_b_addr  = r_j + 1'b1;
        w_fsm_a_wdata = w_b_rdata;
        w_fsm_b_wdata = w_a_rdata;
        case (r_state)
            S_IDLE: begin
                if (start_port) w_next = S_INIT;
            end
            S_INIT: begin
                w_fsm_a_we    = 1'b1;
                w_fsm_a_addr  = r_i;
                w_fsm_a_wdata = '0 - {{(W-IDX_W){1'b0}}, r_i};
                if (r_i == LAST_IDX) w_next = S_OUTER;
            end
            S_OUTER: w_next = S_READ;
            S_READ:  w_next = S_CMP;
            S_CMP: begin
                if ($signed(w_a_rdata) > $signed(w_b_rdata)) w_next = S_SWAP;
                else                                         w_next = S_NEXT;
            end
            S_SWAP: begin
                w_fsm_a_we = 1'b1;
                w_fsm_b_we = 1'b1;
                w_next     = S_NEXT;
            end
            S_NEXT: begin
                if (r_j == w_last_j) begin
                    if ((r_pass == LAST_PASS) || (EARLY_EXIT && !r_swapped)) w_next = S_DONE;
                    else                                                     w_next = S_OUTER;
                end else begin
                    w_next = S_READ;
                end
            end
            S_DONE: begin
                done_port = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_i       <= '0;
            r_j       <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_i <= '0;
                S_INIT: begin
                    r_i    <= r_i + 1'b1;
                    r_pass <= '0;
                end
                S_OUTER: begin
                    r_j       <= '0;
                    r_swapped <= 1'b0;
                end
                S_SWAP: r_swapped <= 1'b1;
                S_NEXT: begin
                    if (r_j == w_last_j) r_pass <= r_pass + 1'b1;
                    else                 r_j    <= r_j + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Writes acknowledge one cycle after sampling, reads one cycle later once RAM data is back.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_pend    <= '0;
            Sout_DataRdy <= '0;
            r_rdata      <= '0;
        end else begin
            r_rd_pend    <= w_rd;
            Sout_DataRdy <= w_wr | r_rd_pend;
            for (int c = 0; c < NCH; c++) begin
                r_rdata[c] <= r_rd_pend[c] ? w_ram_rdata[c] : '0;
            end
        end
    end
endmodule

// File: tb/tb_bsort_main.sv
// tb/tb_bsort_main.sv - self-checking bench for bsort_main with a queue-based slave-port and sort-latency model
module tb_bsort_main;
    localparam int BASE = 256;
    localparam int NW   = 100;

    logic          clock;
    logic          reset;
    logic          start_port;
    logic [1:0]    S_oe_ram;
    logic [1:0]    S_we_ram;
    logic [19:0]   S_addr_ram;
    logic [127:0]  S_Wdata_ram;
    logic [13:0]   S_data_ram_size;
    logic          done_port;
    logic [127:0]  Sout_Rdata_ram;
    logic [1:0]    Sout_DataRdy;

    typedef struct {
        int          due;
        int          ch;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t eq[$];
    int   mdl [NW];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   done_due = -1;
    int   busy_lo  = -1;
    int   busy_hi  = -2;
    int   n_done   = 0;
    int   last_done_cyc = -1;
    bit   chk_en   = 0;
    int   k_start;

    bsort_main #(.MEM_var_26078_26084(BASE)) dut (
        .clock           (clock),
        .reset           (reset),
        .start_port      (start_port),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .done_port       (done_port),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Bubble sort on plain ints, returning cycles spent after INIT (OUTER + 3 per compare + 1 per swap).
    function automatic int run_sort();
        int cost = 0;
        for (int p = 0; p < NW - 1; p++) begin
            bit sw = 0;
            cost += 1;
            for (int j = 0; j <= NW - 2 - p; j++) begin
                cost += 3;
                if (mdl[j] > mdl[j+1]) begin
                    int t = mdl[j];
                    mdl[j] = mdl[j+1];
                    mdl[j+1] = t;
                    cost += 1;
                    sw = 1;
                end
            end
`ifdef BSORT_EARLY_EXIT_EN
            if (!sw) break;
`endif
        end
        return cost;
    endfunction

    always @(negedge clock) begin : cmp_proc
        if (reset && chk_en) begin
            for (int c = 0; c < 2; c++) begin : per_ch
                bit er_any;
                bit er_rd;
                logic [31:0] ed;
                er_any = 0;
                er_rd  = 0;
                ed     = '0;
                foreach (eq[i]) begin
                    if (eq[i].due == cyc && eq[i].ch == c) begin
                        er_any = 1;
                        if (eq[i].rd) begin
                            er_rd = 1;
                            ed    = eq[i].data;
                        end
                    end
                end
                chk($sformatf("rdy%0d", c), 64'(Sout_DataRdy[c]), 64'(er_any));
                if (er_rd || !er_any)
                    chk($sformatf("rdata%0d", c), Sout_Rdata_ram[c*64 +: 64], {32'b0, ed});
            end
            chk("done", 64'(done_port), 64'(cyc == done_due));
            begin : prune
                exp_t keep[$];
                foreach (eq[i]) if (eq[i].due > cyc) keep.push_back(eq[i]);
                eq = keep;
            end
        end
    end

    always @(negedge clock) begin
        if (reset && done_port) begin
            n_done++;
            last_done_cyc = cyc;
        end
    end

    task automatic slave_cycle(input logic [1:0] o, input logic [1:0] w,
                               input logic [9:0] a0, input logic [9:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
        int          k;
        int          aa [2];
        logic [31:0] dd [2];
        bit          busy;
        @(posedge clock);
        #1;
        S_oe_ram    = o;
        S_we_ram    = w;
        S_addr_ram  = {a1, a0};
        S_Wdata_ram = {$urandom(), d1, $urandom(), d0};
        k     = cyc;
        aa[0] = int'(a0);
        aa[1] = int'(a1);
        dd[0] = d0;
        dd[1] = d1;
        busy  = (k + 1 >= busy_lo) && (k + 1 <= busy_hi);
        for (int c = 0; c < 2; c++) begin
            if (!busy && aa[c] >= BASE && aa[c] - BASE < 4 * NW) begin
                if (o[c]) eq.push_back('{k + 2, c, 1'b1, 32'(mdl[(aa[c] - BASE) >> 2])});
                if (w[c]) eq.push_back('{k + 1, c, 1'b0, 32'h0});
            end
        end
        for (int c = 0; c < 2; c++)
            if (!busy && w[c] && aa[c] >= BASE && aa[c] - BASE < 4 * NW)
                mdl[(aa[c] - BASE) >> 2] = int'(dd[c]);
    endtask

    task automatic slave_idle();
        slave_cycle(2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 32'd0);
    endtask

    task automatic read_lit(input int ch, input logic [9:0] a, input logic [31:0] v,
                            input bit rdy, input string nm);
        if (ch == 0) slave_cycle(2'b01, 2'b00, a, 10'd0, 32'd0, 32'd0);
        else         slave_cycle(2'b10, 2'b00, 10'd0, a, 32'd0, 32'd0);
        slave_idle();
        @(posedge clock);
        @(negedge clock);
        chk({nm, "_rdy"}, 64'(Sout_DataRdy[ch]), 64'(rdy));
        chk({nm, "_data"}, Sout_Rdata_ram[ch*64 +: 64], {32'b0, v});
    endtask

    task automatic start_sort(output int k);
        int cost;
        @(posedge clock);
        #1;
        start_port = 1'b1;
        k = cyc;
        for (int i = 0; i < NW; i++) mdl[i] = -i;
        cost = run_sort();
        chk("model_cost", 64'(cost), 64'(19899));
        done_due = k + 1 + NW + cost;
        busy_lo  = k + 2;
        busy_hi  = done_due + 1;
        @(posedge clock);
        #1;
        start_port = 1'b0;
    endtask

    task automatic wait_done(input int k, input bit poke);
        int g   = 0;
        int nd0 = n_done;
        while (cyc < done_due + 1 && g < 30000) begin
            @(negedge clock);
            g++;
            if (poke && cyc == done_due - 1) begin
                @(posedge clock);
                #1 start_port = 1'b1;
                @(posedge clock);
                #1 start_port = 1'b0;
            end
        end
        chk("done_in_budget", 64'(g < 30000), 64'(1));
        chk("done_pulses", 64'(n_done - nd0), 64'(1));
        chk("done_latency", 64'(last_done_cyc - k), 64'(20000));
    endtask

    task automatic readback_all();
        for (int w = 0; w < NW / 2; w++)
            slave_cycle(2'b11, 2'b00, 10'(BASE + 8 * w), 10'(BASE + 8 * w + 4), 32'd0, 32'd0);
        slave_idle();
        repeat (3) @(posedge clock);
    endtask

    initial begin
        reset           = 1'b0;
        start_port      = 1'b0;
        S_oe_ram        = '0;
        S_we_ram        = '0;
        S_addr_ram      = '0;
        S_Wdata_ram     = '0;
        S_data_ram_size = {7'd32, 7'd32};
        @(posedge clock);
        #1;
        chk("rst_done", 64'(done_port), 64'(0));
        chk("rst_rdy", 64'(Sout_DataRdy), 64'(0));
        chk("rst_rdata", Sout_Rdata_ram[63:0] | Sout_Rdata_ram[127:64], 64'(0));
        @(posedge clock);
        #1;
        reset  = 1'b1;
        chk_en = 1;

        slave_cycle(2'b00, 2'b11, 10'd256, 10'd260, 32'h5, 32'h3);
        slave_cycle(2'b00, 2'b01, 10'd100, 10'd0, 32'h7, 32'h0);
        slave_cycle(2'b11, 2'b00, 10'd256, 10'd260, 32'h0, 32'h0);
        slave_cycle(2'b01, 2'b00, 10'd260, 10'd0, 32'h0, 32'h0);
        slave_idle();
        read_lit(0, 10'd256, 32'h5, 1'b1, "rd256");
        read_lit(1, 10'd260, 32'h3, 1'b1, "rd260");
        read_lit(0, 10'd656, 32'h0, 1'b0, "rd656_oor");
        slave_cycle(2'b00, 2'b11, 10'd300, 10'd300, 32'h1, 32'h2);
        read_lit(0, 10'd300, 32'h2, 1'b1, "collide");

        start_sort(k_start);
        repeat (50) @(posedge clock);
        slave_cycle(2'b11, 2'b01, 10'd256, 10'd260, 32'h77, 32'h0);
        slave_idle();
        @(posedge clock);
        #1 start_port = 1'b1;
        @(posedge clock);
        #1 start_port = 1'b0;
        wait_done(k_start, 1'b1);
        readback_all();
        read_lit(0, 10'd256, 32'hFFFFFF9D, 1'b1, "sorted_w0");
        read_lit(1, 10'd652, 32'h0, 1'b1, "sorted_w99");

        start_sort(k_start);
        repeat (500) @(posedge clock);
        #1 reset = 1'b0;
        done_due = -1;
        busy_lo  = -1;
        busy_hi  = -2;
        eq.delete();
        #1;
        chk("midrst_done", 64'(done_port), 64'(0));
        chk("midrst_rdy", 64'(Sout_DataRdy), 64'(0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        start_sort(k_start);
        wait_done(k_start, 1'b0);
        readback_all();
        read_lit(0, 10'd256, 32'hFFFFFF9D, 1'b1, "resort_w0");
        read_lit(1, 10'd652, 32'h0, 1'b1, "resort_w99");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1500000;
        n_err++;
        $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
